// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: md_op encodings, default latencies and FSM state type shared by the MDU.
package mdu_ctrl_pkg;
  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;
  typedef enum logic {S_IDLE, S_RUN} state_t;
endpackage

// File: rtl/mdu_ctrl_arith.sv
// mdu_ctrl_arith: combinational multiply/divide producing {hi,lo} and a divide-by-zero flag.
module mdu_ctrl_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [63:0] o_res,
  output logic        o_div_by_zero
);
  logic        w_sgn, w_div, w_an, w_bn;
  logic [63:0] w_ea, w_eb, w_prod;
  logic [31:0] w_ua, w_ub, w_qm, w_rm, w_quo, w_rem;
  assign w_sgn = (md_op == MD_MULT) || (md_op == MD_DIV);
  assign w_div = (md_op == MD_DIV) || (md_op == MD_DIVU);
  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign w_ea   = {{32{w_sgn & A[31]}}, A};
  assign w_eb   = {{32{w_sgn & B[31]}}, B};
  assign w_prod = w_ea * w_eb;
  // Signed division via magnitudes avoids the INT_MIN / -1 overflow case.
  assign w_an  = w_sgn & A[31];
  assign w_bn  = w_sgn & B[31];
  assign w_ua  = w_an ? -A : A;
  assign w_ub  = w_bn ? -B : B;
  assign w_qm  = (w_ub == 32'd0) ? 32'd0 : w_ua / w_ub;
  assign w_rm  = (w_ub == 32'd0) ? 32'd0 : w_ua % w_ub;
  assign w_quo = (w_an ^ w_bn) ? -w_qm : w_qm;
  assign w_rem = w_an ? -w_rm : w_rm;
  assign o_res         = w_div ? {w_rem, w_quo} : w_prod;
  assign o_div_by_zero = w_div && (B == 32'd0);
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: HI/LO owner that runs fixed-latency MULT/DIV windows and commits at their end.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  state_t             r_state, w_state_nx;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
  logic [63:0]        r_pend, w_pend_nx, w_res;
  logic               r_pend_dz, w_pend_dz_nx, w_dz;
  logic [31:0]        r_hi, r_lo, w_hi_nx, w_lo_nx;
  mdu_ctrl_arith u_arith (
    .md_op(md_op),
    .A(A),
    .B(B),
    .o_res(w_res),
    .o_div_by_zero(w_dz)
  );
  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_pend_nx    = r_pend;
    w_pend_dz_nx = r_pend_dz;
    w_hi_nx      = r_hi;
    w_lo_nx      = r_lo;
    if (r_state == S_IDLE) begin
      if (start) begin
        case (md_op)
          MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
            w_state_nx   = S_RUN;
            w_pend_nx    = w_res;
            w_pend_dz_nx = w_dz;
            w_cnt_nx     = (md_op == MD_DIV || md_op == MD_DIVU) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          end
          MD_MTHI: w_hi_nx = A;
          MD_MTLO: w_lo_nx = A;
          default: ;
        endcase
      end
    end else if (r_cnt == CNT_W'(1)) begin
      w_state_nx = S_IDLE;
      w_cnt_nx   = '0;
      w_hi_nx    = r_pend_dz ? r_hi : r_pend[63:32];
      w_lo_nx    = r_pend_dz ? r_lo : r_pend[31:0];
    end else begin
      w_cnt_nx = r_cnt - CNT_W'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pend    <= '0;
      r_pend_dz <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_pend    <= w_pend_nx;
      r_pend_dz <= w_pend_dz_nx;
      r_hi      <= w_hi_nx;
      r_lo      <= w_lo_nx;
    end
  end
  assign busy = (r_state == S_RUN);
  assign hi   = r_hi;
  assign lo   = r_lo;
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed stimulus with an arithmetic/time-based reference model checked every cycle.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;
  logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [2:0]  md_op = 3'b000;
  logic [31:0] A = '0, B = '0;
  logic        busy;
  logic [31:0] hi, lo;
  int checks = 0, failures = 0;
  logic chk_en = 1'b0;
  mdu_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .A(A), .B(B), .busy(busy), .hi(hi), .lo(lo)
  );
  initial forever #5 clk = ~clk;
  longint      e_cnt = 0, m_commit = 0;
  logic        m_pend = 1'b0, m_ok = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
  // Reference result: {write_enable, hi, lo} from plain 64-bit arithmetic.
  function automatic logic [64:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          s, r;
    longint unsigned u, v;
    case (op)
      MD_MULT:  begin s = longint'($signed(a)) * longint'($signed(b)); return {1'b1, s[63:0]}; end
      MD_MULTU: begin u = {32'd0, a} * {32'd0, b}; return {1'b1, u[63:0]}; end
      MD_DIV: begin
        if (b == 0) return '0;
        s = longint'($signed(a)) / longint'($signed(b));
        r = longint'($signed(a)) % longint'($signed(b));
        return {1'b1, r[31:0], s[31:0]};
      end
      default: begin
        if (b == 0) return '0;
        u = {32'd0, a} / {32'd0, b};
        v = {32'd0, a} % {32'd0, b};
        return {1'b1, v[31:0], u[31:0]};
      end
    endcase
  endfunction
  always @(posedge clk) begin
    logic [64:0] res;
    e_cnt <= e_cnt + 1;
    if (!reset) begin
      m_pend <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else if (m_pend) begin
      if (e_cnt == m_commit) begin
        m_pend <= 1'b0;
        if (m_ok) begin
          m_hi <= m_phi;
          m_lo <= m_plo;
        end
      end
    end else if (start) begin
      if (md_op <= MD_DIVU) begin
        res      = ref_op(md_op, A, B);
        m_pend   <= 1'b1;
        m_commit <= e_cnt + ((md_op >= MD_DIV) ? 10 : 5);
        {m_ok, m_phi, m_plo} <= res;
      end else if (md_op == MD_MTHI) m_hi <= A;
      else if (md_op == MD_MTLO) m_lo <= A;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_busy", {31'd0, busy}, {31'd0, m_pend});
      chk("model_hi", hi, m_hi);
      chk("model_lo", lo, m_lo);
    end
  end
  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_busy(input string nm, input int exp_n, input logic [31:0] hold_hi, input logic [31:0] hold_lo);
    int n = 0;
    while (busy && n < 40) begin
      chk({nm, "_hold_hi"}, hi, hold_hi);
      chk({nm, "_hold_lo"}, lo, hold_lo);
      n++;
      @(negedge clk);
    end
    chk({nm, "_busy_cycles"}, n, exp_n);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    reset = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    drive(MD_MULT, 32'hFFFFFFFF, 32'h2);
    wait_busy("mult", 5, 32'h0, 32'h0);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFE);
    drive(MD_MULTU, 32'hFFFFFFFF, 32'h2);
    wait_busy("multu_b2b", 5, 32'hFFFFFFFF, 32'hFFFFFFFE);
    chk("multu_hi", hi, 32'h00000001);
    chk("multu_lo", lo, 32'hFFFFFFFE);
    drive(MD_DIV, 32'hFFFFFFF9, 32'h2);
    wait_busy("div", 10, 32'h00000001, 32'hFFFFFFFE);
    chk("div_hi", hi, 32'hFFFFFFFF);
    chk("div_lo", lo, 32'hFFFFFFFD);
    drive(MD_DIVU, 32'h7, 32'h2);
    wait_busy("divu", 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    chk("divu_hi", hi, 32'h1);
    chk("divu_lo", lo, 32'h3);
    drive(MD_MTHI, 32'h11, 32'h0);
    drive(MD_MTLO, 32'h22, 32'h0);
    chk("mt_busy", {31'd0, busy}, 32'd0);
    drive(MD_DIVU, 32'h1234, 32'h0);
    wait_busy("divz", 10, 32'h11, 32'h22);
    chk("divz_hi", hi, 32'h11);
    chk("divz_lo", lo, 32'h22);
    drive(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_busy("divovf", 10, 32'h11, 32'h22);
    chk("divovf_hi", hi, 32'h0);
    chk("divovf_lo", lo, 32'h80000000);
    drive(MD_MULT, 32'h3, 32'h4);
    @(negedge clk);
    drive(MD_DIV, 32'd100, 32'd7);
    wait_busy("ign", 3, 32'h0, 32'h80000000);
    chk("ign_hi", hi, 32'h0);
    chk("ign_lo", lo, 32'hC);
    drive(MD_MTHI, 32'h5A5A, 32'h0);
    drive(MD_MTLO, 32'hDEADBEEF, 32'h0);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    chk("mtlo_lo", lo, 32'hDEADBEEF);
    chk("mtlo_hi", hi, 32'h5A5A);
    drive(3'b110, 32'h99, 32'h1);
    drive(3'b111, 32'h99, 32'h1);
    chk("illegal_busy", {31'd0, busy}, 32'd0);
    chk("illegal_hi", hi, 32'h5A5A);
    chk("illegal_lo", lo, 32'hDEADBEEF);
    drive(MD_MULT, 32'hFFFFFFFF, 32'h2);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_hi", hi, 32'h0);
    chk("rst_mid_lo", lo, 32'h0);
    repeat (8) @(negedge clk);
    chk("rst_nocommit_hi", hi, 32'h0);
    chk("rst_nocommit_lo", lo, 32'h0);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multi-cycle multiply/divide controller that sits beside the single-cycle ALU in the EX stage of the pipelined MIPS core.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from EX and owns the HI/LO architectural registers.
- Sequences a fixed-latency busy window and commits HI/LO at its end.
- Exposes `busy` so the hazard unit can stall later MD-class instructions.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be ≥ 1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be ≥ 1).
- CNT_W, 4, counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- start  in  1  request valid this cycle (EX-stage instruction is an MD op).
- md_op  in  3  operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- A  in  32  rs operand (dividend / multiplicand / MTHI-MTLO source).
- B  in  32  rt operand (divisor / multiplier).
- busy  out  1  multi-cycle operation in flight.
- hi  out  32  HI register, read by MFHI in EX.
- lo  out  32  LO register, read by MFLO in EX.

Behaviour:
- Reset: when reset==0 at a rising edge, clear `busy`, `hi`, `lo`, the counter and the pending result to 0. Reset overrides everything, including an in-flight operation; the pending result is discarded.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter counts down.
- Accept rule: a request is accepted only when start=1, busy=0 and not in reset. start while busy=1 is ignored with no state change; the hazard unit guarantees this never happens legally.
- MULT/MULTU accepted at edge T:
  - Compute the 64-bit product at the accept edge and latch it into pending_hi/pending_lo.
    - MULT: $signed × $signed.
    - MULTU: unsigned.
  - Load the counter with MULT_CYCLES.
  - busy=1 for cycles T+1 … T+MULT_CYCLES.
  - At edge T+MULT_CYCLES: hi/lo ← pending, busy ← 0.
  - hi/lo keep their old values throughout RUN.
- DIV/DIVU: identical flow with DIV_CYCLES.
  - lo = quotient, hi = remainder.
  - DIV: truncation toward zero; remainder takes the dividend's sign.
  - DIVU: unsigned.
  - B==0: operation still runs the full DIV_CYCLES busy window; hi/lo are left unchanged at commit.
  - Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wrap, no trap).
- MTHI/MTLO accepted at edge T: hi (resp. lo) ← A at that edge; busy stays 0; no RUN state.
- Illegal md_op with start=1: ignored; no state change.
- Counter: decrements each cycle in RUN; commit when counter==1 at an edge; the counter never wraps.
- Back-to-back: a new start may be accepted on the cycle right after the commit edge (busy=0). It cannot be accepted on the commit edge itself, because busy was still 1.
- No output has any combinational path from start/A/B; all outputs are registered.
- Flush is not supported: an accepted operation always completes unless reset is asserted.

Decomposition:
- Shared macros header holds the md_op encodings:
  - MD_MULT=3'b000, MD_MULTU=3'b001, MD_DIV=3'b010, MD_DIVU=3'b011, MD_MTHI=3'b100, MD_MTLO=3'b101.
  - Defaults for MULT_CYCLES and DIV_CYCLES.
- Optional combinational sub-module `mdu_arith` (A, B, md_op → 64-bit {hi,lo} result plus a div_by_zero flag). It keeps the signed/unsigned arithmetic separate from the sequencing FSM; `mdu_ctrl` instantiates it once.

Test Plan:
- Reset mid-operation: MULT started, reset=0 at cycle 3 → next cycle busy=0, hi=0, lo=0; no later commit.
- MULT A=0xFFFFFFFF, B=0x00000002:
  - Signed → busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - Same operands with MULTU → hi=0x00000001, lo=0xFFFFFFFE.
  - hi/lo hold their prior values during busy.
- DIV A=0xFFFFFFF9 (−7), B=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU A=7, B=2 → lo=3, hi=1.
- Division by zero: preload hi=0x11, lo=0x22 via MTHI/MTLO, then DIVU B=0 → busy 10 cycles, then hi=0x11, lo=0x22 unchanged.
- start during busy:
  - MULT running, then a DIV request at cycle 2 of busy → ignored; busy drops after the original 5 cycles with the MULT result.
  - A MULT issued the cycle after the commit is accepted.
- MTLO A=0xDEADBEEF with busy=0 → lo=0xDEADBEEF after one edge, busy never asserts, hi unchanged.
